adventure_grid: RTL and testbench
=================================

ADVENTURE_GRID -- requirements
Module: adventure_grid

Interface
REQ-001 SHALL have parameter ROWS, default 3, grid row count (2..16).
REQ-002 SHALL have parameter COLS, default 3, grid column count (2..16).
REQ-003 SHALL have parameters SWORD_ROW/SWORD_COL, default 2/0, sword room coordinates.
REQ-004 SHALL have parameters DRAGON_ROW/DRAGON_COL, default 2/2, dragon room coordinates; never (0,0) and never equal to the sword room.
REQ-005 SHALL have parameter MAX_MOVES, default 16, move budget (1..255), used only under REQ-030.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports n, s, e, w  input  1 each  direction requests, sampled every rising edge.
REQ-009 SHALL have port row  output  RW=max(1,clog2(ROWS))  current row.
REQ-010 SHALL have port col  output  CW=max(1,clog2(COLS))  current column.
REQ-011 SHALL have port has_sword  output  1  sword collected.
REQ-012 SHALL have port in_dragon  output  1  high while in DRAGON state.
REQ-013 SHALL have ports win, die  output  1 each  terminal outcome flags.
REQ-014 SHALL have port moves  output  8  accepted-move count.

Function
REQ-015 SHALL implement states EXPLORE, DRAGON, WIN, DIE; all outputs registered.
REQ-016 SHALL, in EXPLORE, accept at most one direction per edge, priority n > s > e > w.
REQ-017 SHALL map n: row-1, s: row+1, e: col+1, w: col-1.
REQ-018 SHALL ignore a move leaving the grid (row/col unchanged, moves unchanged); lower-priority requests are not considered instead.
REQ-019 SHALL increment moves by 1 per accepted move, saturating at 255.
REQ-020 SHALL set has_sword on the same edge that moves position onto the sword room; has_sword stays set until reset.
REQ-021 SHALL enter DRAGON on the edge that moves position onto the dragon room; in_dragon=1 from that edge.
REQ-022 SHALL leave DRAGON after exactly one cycle regardless of inputs: to WIN if has_sword=1, else DIE; in_dragon clears on that edge.
REQ-023 SHALL hold WIN (win=1) or DIE (die=1) with row/col/moves frozen and all inputs ignored until reset.
REQ-024 SHALL never assert win and die together.
REQ-025 SHALL ignore all direction inputs in DRAGON, WIN, DIE.

Reset
REQ-026 SHALL, while reset=0, force state EXPLORE, row=0, col=0, has_sword=0, in_dragon=0, win=0, die=0, moves=0, asynchronously.
REQ-027 SHALL honour reset assertion in any state, including mid-DRAGON, discarding progress.
REQ-028 SHALL accept the first move on the first rising edge at which reset is already high.
REQ-029 SHALL not collect the sword at reset even if the sword room is (0,0); it is collected only by re-entering.

Configuration
REQ-030 SHALL compile the move limit only when macro ADVENTURE_GRID_MOVE_LIMIT_EN is defined.
REQ-031 SHALL, with the macro, go to DIE on the edge accepting move number MAX_MOVES unless that move enters the dragon room (then REQ-021 applies); position updates to the target room.
REQ-032 SHALL, without the macro, have no move limit; MAX_MOVES unused; moves saturates only.

Verification
REQ-033 SHALL cover, defaults: e,e,s,s one per cycle from reset -> (2,2), in_dragon=1 one cycle, then die=1, win=0, moves=4.
REQ-034 SHALL cover: s,s,e,e -> has_sword=1 after 2nd s at (2,0), dragon at (2,2), then win=1, moves=4.
REQ-035 SHALL cover: n at (0,0), then w at (0,0) -> row=0, col=0, moves=0; then n+e together at (1,0) -> (0,0), moves incremented.
REQ-036 SHALL cover: reset pulsed low mid-DRAGON -> all outputs 0 immediately, no win/die pulse after release.
REQ-037 SHALL cover with macro, MAX_MOVES=4: e,w,e,w -> die=1 on 4th accepted edge, moves=4, further inputs ignored; without macro same stimulus -> EXPLORE, moves=4.
REQ-038 SHALL cover after win: inputs n,s,e,w toggled 10 cycles -> win=1, row/col/moves unchanged.

Source files
------------

// File: rtl/adventure_grid.sv
// adventure_grid: grid-walking adventure FSM. The player starts at (0,0), picks
// up the sword, and meets the dragon for a WIN (armed) or DIE (unarmed) outcome.
// Optional macro ADVENTURE_GRID_MOVE_LIMIT_EN adds a MAX_MOVES move budget that
// ends the game in DIE when it runs out.
module adventure_grid #(
   parameter int unsigned ROWS       = 3,
   parameter int unsigned COLS       = 3,
   parameter int unsigned SWORD_ROW  = 2,
   parameter int unsigned SWORD_COL  = 0,
   parameter int unsigned DRAGON_ROW = 2,
   parameter int unsigned DRAGON_COL = 2,
   parameter int unsigned MAX_MOVES  = 16,
   localparam int unsigned RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned CW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          n,
   input  logic          s,
   input  logic          e,
   input  logic          w,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          has_sword,
   output logic          in_dragon,
   output logic          win,
   output logic          die,
   output logic [7:0]    moves
);

   typedef enum logic [1:0] {
      ST_EXPLORE = 2'd0,
      ST_DRAGON  = 2'd1,
      ST_WIN     = 2'd2,
      ST_DIE     = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          has_sword_q, has_sword_d;
   logic          in_dragon_q, in_dragon_d;
   logic          win_q, win_d;
   logic          die_q, die_d;
   logic [7:0]    moves_q, moves_d;

   logic          go_c;
   logic [RW-1:0] tgt_row_c;
   logic [CW-1:0] tgt_col_c;
   logic          tgt_sword_c;
   logic          tgt_dragon_c;

`ifndef ADVENTURE_GRID_MOVE_LIMIT_EN
   logic unused_max_moves_c;
   assign unused_max_moves_c = ^8'(MAX_MOVES);
`endif

   // Highest-priority request picks the target; a wall-blocked request is dropped outright.
   always_comb begin
      go_c      = 1'b0;
      tgt_row_c = row_q;
      tgt_col_c = col_q;
      if (n) begin
         go_c      = (row_q != '0);
         tgt_row_c = row_q - RW'(1);
      end else if (s) begin
         go_c      = (row_q != RW'(ROWS - 1));
         tgt_row_c = row_q + RW'(1);
      end else if (e) begin
         go_c      = (col_q != CW'(COLS - 1));
         tgt_col_c = col_q + CW'(1);
      end else if (w) begin
         go_c      = (col_q != '0);
         tgt_col_c = col_q - CW'(1);
      end
      tgt_sword_c  = (tgt_row_c == RW'(SWORD_ROW))  && (tgt_col_c == CW'(SWORD_COL));
      tgt_dragon_c = (tgt_row_c == RW'(DRAGON_ROW)) && (tgt_col_c == CW'(DRAGON_COL));
   end

   // Next-state and next-output logic; terminal states simply hold everything.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      has_sword_d = has_sword_q;
      in_dragon_d = in_dragon_q;
      win_d       = win_q;
      die_d       = die_q;
      moves_d     = moves_q;
      case (state_q)
         ST_EXPLORE: begin
            if (go_c) begin
               row_d   = tgt_row_c;
               col_d   = tgt_col_c;
               moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
               if (tgt_sword_c) begin
                  has_sword_d = 1'b1;
               end
               if (tgt_dragon_c) begin
                  state_d     = ST_DRAGON;
                  in_dragon_d = 1'b1;
               end
`ifdef ADVENTURE_GRID_MOVE_LIMIT_EN
               else if ((9'(moves_q) + 9'd1) == 9'(MAX_MOVES)) begin
                  state_d = ST_DIE;
                  die_d   = 1'b1;
               end
`endif
            end
         end
         ST_DRAGON: begin
            in_dragon_d = 1'b0;
            if (has_sword_q) begin
               state_d = ST_WIN;
               win_d   = 1'b1;
            end else begin
               state_d = ST_DIE;
               die_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_EXPLORE;
         row_q       <= '0;
         col_q       <= '0;
         has_sword_q <= 1'b0;
         in_dragon_q <= 1'b0;
         win_q       <= 1'b0;
         die_q       <= 1'b0;
         moves_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         has_sword_q <= has_sword_d;
         in_dragon_q <= in_dragon_d;
         win_q       <= win_d;
         die_q       <= die_d;
         moves_q     <= moves_d;
      end
   end

   assign row       = row_q;
   assign col       = col_q;
   assign has_sword = has_sword_q;
   assign in_dragon = in_dragon_q;
   assign win       = win_q;
   assign die       = die_q;
   assign moves     = moves_q;

endmodule

// File: tb/tb_adventure_grid.sv
// Bench for adventure_grid (3x3 defaults, MAX_MOVES=4 so the limit is reachable
// when ADVENTURE_GRID_MOVE_LIMIT_EN is defined).
module tb_adventure_grid;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
      logic       sword;
      logic       dragon;
      logic       win;
      logic       die;
      logic [7:0] moves;
   } out_t;

   typedef struct {
      string      lbl;
      logic [3:0] nsew;
      out_t       exp;
   } vec_t;

   localparam logic [3:0] Z = 4'b0000;
   localparam logic [3:0] N = 4'b1000;
   localparam logic [3:0] S = 4'b0100;
   localparam logic [3:0] E = 4'b0010;
   localparam logic [3:0] W = 4'b0001;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       n_i = 1'b0, s_i = 1'b0, e_i = 1'b0, w_i = 1'b0;
   logic [1:0] row, col;
   logic       has_sword, in_dragon, win, die;
   logic [7:0] moves;
   out_t       act;

   out_t  exp_q[$];
   string lbl_q[$];
   vec_t  tbl[$];
   int    n_cmp = 0;
   int    n_err = 0;

   adventure_grid #(.MAX_MOVES(4)) dut (
      .clk(clk), .reset(reset),
      .n(n_i), .s(s_i), .e(e_i), .w(w_i),
      .row(row), .col(col), .has_sword(has_sword), .in_dragon(in_dragon),
      .win(win), .die(die), .moves(moves)
   );

   assign act = {row, col, has_sword, in_dragon, win, die, moves};

   always #5 clk = ~clk;

   function automatic out_t mk(int r, int c, bit sw, bit dr, bit wi, bit di, int mv);
      out_t o;
      o.row = 2'(r); o.col = 2'(c); o.sword = sw; o.dragon = dr;
      o.win = wi; o.die = di; o.moves = 8'(mv);
      return o;
   endfunction

   function automatic void add(string l, logic [3:0] d, out_t x);
      vec_t v;
      v.lbl = l; v.nsew = d; v.exp = x;
      tbl.push_back(v);
   endfunction

   task automatic check();
      out_t  x;
      string l;
      x = exp_q.pop_front();
      l = lbl_q.pop_front();
      n_cmp++;
      if (act !== x) begin
         n_err++;
         $display("FAIL %s: got row=%0d col=%0d sw=%b dr=%b win=%b die=%b moves=%0d, want row=%0d col=%0d sw=%b dr=%b win=%b die=%b moves=%0d",
                  l, act.row, act.col, act.sword, act.dragon, act.win, act.die, act.moves,
                  x.row, x.col, x.sword, x.dragon, x.win, x.die, x.moves);
      end
   endtask

   task automatic expect_now(string l, out_t x);
      exp_q.push_back(x);
      lbl_q.push_back(l);
      check();
   endtask

   task automatic step(string l, logic [3:0] d, out_t x);
      {n_i, s_i, e_i, w_i} = d;
      exp_q.push_back(x);
      lbl_q.push_back(l);
      @(posedge clk);
      #1;
      check();
   endtask

   task automatic run_table();
      foreach (tbl[i]) step(tbl[i].lbl, tbl[i].nsew, tbl[i].exp);
      tbl.delete();
   endtask

   // Asserted away from the clock edge, checked immediately, released after one edge.
   task automatic do_reset(string l);
      reset = 1'b0;
      {n_i, s_i, e_i, w_i} = Z;
      #1;
      expect_now({l, "_async"}, mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      expect_now({l, "_held"}, mk(0, 0, 0, 0, 0, 0, 0));
      reset = 1'b1;
   endtask

   initial begin
      #2;
      do_reset("rst0");

      // Unarmed walk into the dragon
      add("lose_e1", E, mk(0, 1, 0, 0, 0, 0, 1));
      add("lose_e2", E, mk(0, 2, 0, 0, 0, 0, 2));
      add("lose_s1", S, mk(1, 2, 0, 0, 0, 0, 3));
      add("lose_s2", S, mk(2, 2, 0, 1, 0, 0, 4));
      add("lose_die", Z, mk(2, 2, 0, 0, 0, 1, 4));
      add("lose_hold", E | N, mk(2, 2, 0, 0, 0, 1, 4));
      run_table();

      // Armed walk: sword at (2,0), then dragon
      do_reset("rst1");
      add("win_s1", S, mk(1, 0, 0, 0, 0, 0, 1));
      add("win_s2", S, mk(2, 0, 1, 0, 0, 0, 2));
      add("win_e1", E, mk(2, 1, 1, 0, 0, 0, 3));
      add("win_e2", E, mk(2, 2, 1, 1, 0, 0, 4));
      add("win_win", N, mk(2, 2, 1, 0, 1, 0, 4));
      run_table();
      for (int i = 0; i < 10; i++) begin
         step("win_frozen", 4'((i % 2 == 0) ? 4'b1111 : 4'(1 << (i % 4))),
              mk(2, 2, 1, 0, 1, 0, 4));
      end

      // Wall and priority corners
      do_reset("rst2");
      add("wall_n", N, mk(0, 0, 0, 0, 0, 0, 0));
      add("wall_w", W, mk(0, 0, 0, 0, 0, 0, 0));
      add("wall_ne", N | E, mk(0, 0, 0, 0, 0, 0, 0));
      add("prio_sw", S | W, mk(1, 0, 0, 0, 0, 0, 1));
      add("prio_ne", N | E, mk(0, 0, 0, 0, 0, 0, 2));
      run_table();

      do_reset("rst3");
      add("east_1", E, mk(0, 1, 0, 0, 0, 0, 1));
      add("east_2", E, mk(0, 2, 0, 0, 0, 0, 2));
      add("east_wall", E | W, mk(0, 2, 0, 0, 0, 0, 2));
      add("east_s", S | W, mk(1, 2, 0, 0, 0, 0, 3));
      run_table();

      // Reset pulse while in the dragon room
      do_reset("rst4");
      add("md_e1", E, mk(0, 1, 0, 0, 0, 0, 1));
      add("md_e2", E, mk(0, 2, 0, 0, 0, 0, 2));
      add("md_s1", S, mk(1, 2, 0, 0, 0, 0, 3));
      add("md_s2", S, mk(2, 2, 0, 1, 0, 0, 4));
      run_table();
      reset = 1'b0;
      #1;
      expect_now("md_reset_now", mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      expect_now("md_reset_held", mk(0, 0, 0, 0, 0, 0, 0));
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step("md_after", Z, mk(0, 0, 0, 0, 0, 0, 0));

      // Move budget
      do_reset("rst5");
      add("lim_e1", E, mk(0, 1, 0, 0, 0, 0, 1));
      add("lim_w1", W, mk(0, 0, 0, 0, 0, 0, 2));
      add("lim_e2", E, mk(0, 1, 0, 0, 0, 0, 3));
`ifdef ADVENTURE_GRID_MOVE_LIMIT_EN
      add("lim_w2", W, mk(0, 0, 0, 0, 0, 1, 4));
      add("lim_frozen", E, mk(0, 0, 0, 0, 0, 1, 4));
      add("lim_frozen2", S, mk(0, 0, 0, 0, 0, 1, 4));
`else
      add("lim_w2", W, mk(0, 0, 0, 0, 0, 0, 4));
      add("lim_more", E, mk(0, 1, 0, 0, 0, 0, 5));
`endif
      run_table();

`ifndef ADVENTURE_GRID_MOVE_LIMIT_EN
      // Move counter saturation
      do_reset("rst6");
      for (int i = 0; i < 260; i++) begin
         step("sat", (i % 2 == 0) ? E : W,
              mk((i % 2 == 0) ? 0 : 0, (i % 2 == 0) ? 1 : 0, 0, 0, 0, 0,
                 (i + 1 > 255) ? 255 : i + 1));
      end
`endif

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
